ili_fill_rect: RTL and testbench
================================

Name: ili_fill_rect

Overview:
- Upstream byte source for the SPI master path. It replaces the static command array feeder while a fill is in progress.
- On a start strobe it emits the ILI9341 window and memory-write sequence: CASET, PASET, RAMWR, then one RGB565 colour for every pixel in the rectangle.
- Each byte goes out with its D/C and CS levels, one byte per send/sent handshake, into spi_ctrl/spi_shift.
- Runs on the divided clock domain used by the rest of the ili path.

Parameters:
- LCD_W, 240, panel width in pixels; x coordinates must be < LCD_W.
- LCD_H, 320, panel height in pixels; y coordinates must be < LCD_H.

Ports:
- clk  in  1  divided system clock
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle start strobe; ignored unless idle
- i_x0  in  16  left column
- i_x1  in  16  right column, inclusive
- i_y0  in  16  top row
- i_y1  in  16  bottom row, inclusive
- i_color  in  16  RGB565 fill colour
- i_byte_sent  in  1  one-cycle pulse from spi_ctrl done: current byte shifted out
- o_send  out  1  one-cycle request to shift o_data
- o_data  out  8  byte to transmit
- o_dc  out  1  0 = command byte, 1 = data byte
- o_cs  out  1  panel chip select, active-low
- o_busy  out  1  high from the cycle after an accepted start until o_done
- o_done  out  1  one-cycle pulse after the last byte is acknowledged
- o_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset values: o_send=0, o_data=8'h00, o_dc=0, o_cs=1, o_busy=0, o_done=0, o_err=0. Reset mid-fill aborts immediately and CS deasserts asynchronously.
- Start is accepted only in IDLE. All inputs are latched on the start cycle, so later input changes have no effect.
- Start is rejected when x1<x0, y1<y0, x1>=LCD_W or y1>=LCD_H. On rejection: o_err pulses the next cycle, the block stays in IDLE and sends no bytes.
- States:
  - IDLE: on a valid start, go to SEND.
  - SEND: o_send=1 for exactly one cycle, then WAIT.
  - WAIT: hold o_data/o_dc until i_byte_sent. Then go to SEND for the next byte, or to FINISH after the last byte.
  - FINISH: o_cs=1, o_done=1 for one cycle, then IDLE.
- o_cs goes low on the first SEND cycle and stays low for the whole sequence. o_busy follows the same window.
- o_data and o_dc are valid on the SEND cycle and stay stable through WAIT.
- Header sequence, 11 bytes, tracked by a 4-bit index:
  - 0x2A(c), x0[15:8], x0[7:0], x1[15:8], x1[7:0]
  - 0x2B(c), y0[15:8], y0[7:0], y1[15:8], y1[7:0]
  - 0x2C(c)
  - (c) marks o_dc=0; every other byte has o_dc=1.
- Pixel phase:
  - Per pixel: colour[15:8] then colour[7:0], both with o_dc=1.
  - Column counter runs x0..x1; on wrap it resets to x0 and increments the row counter y0..y1.
  - The last byte is the low byte at (x1,y1).
  - Total bytes = 11 + 2*(x1-x0+1)*(y1-y0+1). Maximum 153611, so any total counter must be at least 18 bits.
- Throughput: the next o_send is asserted on the cycle after i_byte_sent, giving a one-cycle gap between bytes.
- Simultaneous events:
  - i_byte_sent outside WAIT is ignored.
  - i_start during busy is ignored; no o_err is raised.
  - i_start on the FINISH cycle is ignored.

Optional Feature:
- Macro ILI_FILL_CHECKER_EN.
- When defined, the block adds inputs i_color_alt (16) and i_checker (1), both latched at start.
- With i_checker=1, the pixel at (x,y) uses i_color_alt when (x[0]^y[0])=1, otherwise i_color.
- When the macro is not defined, the ports do not exist and every pixel uses i_color.

Decomposition:
- pkg_ili9341 holds:
  - command constants ILI_CASET=8'h2A, ILI_PASET=8'h2B, ILI_RAMWR=8'h2C
  - the state enum e_fill_state
  - struct st_fill_req with x0, x1, y0, y1, color fields
- One sub-module, ili_pix_cnt: x/y counters with load, advance and last-pixel flag. It keeps the byte mux in the top free of counter logic.

Test Plan:
- Single pixel: start (5,5)-(5,5), colour 16'hF800 → 13 bytes: 2A,00,05,00,05,2B,00,05,00,05,2C,F8,00. o_dc=0 only on bytes 1, 6 and 11; CS low throughout; o_done once.
- Full screen: (0,0)-(239,319), colour 16'h07E0 → exactly 153611 o_send pulses. Last byte is 8'hE0 and o_done follows.
- Reject: x0=10, x1=9 → o_err pulse, o_send stays 0, o_cs stays 1. A second start with x1=240 (LCD_W=240) → o_err.
- Handshake stall: delay i_byte_sent by 0, 1 and 50 cycles → o_data/o_dc stable while waiting; exactly one o_send per byte; new o_send one cycle after each ack.
- Abort: assert rst after the 20th byte of a 4x4 fill → all outputs return to reset values immediately. A following start (0,0)-(1,0) then completes cleanly with 15 bytes.
- Checker (macro defined): (0,0)-(1,1) with colours 16'h0000/16'hFFFF → pixel bytes 00,00,FF,FF,FF,FF,00,00. A start during busy is ignored.

Source files
------------

// File: rtl/ili_fill_rect_pkg.sv
// Shared definitions for the ILI9341 rectangle-fill byte source: panel
// command bytes, the fill FSM state type and the latched fill request.
package pkg_ili9341;

  localparam logic [7:0] ILI_CASET = 8'h2A;
  localparam logic [7:0] ILI_PASET = 8'h2B;
  localparam logic [7:0] ILI_RAMWR = 8'h2C;

  // Index of the last header byte (RAMWR) in the 11-byte window sequence.
  localparam logic [3:0] HDR_LAST = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_FINISH
  } e_fill_state;

  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] y0;
    logic [15:0] y1;
    logic [15:0] color;
  } st_fill_req;

endpackage

// File: rtl/ili_fill_rect_if.sv
// Byte stream between the fill source and spi_ctrl/spi_shift: one byte per
// send/byte_sent handshake, tagged with its D/C level and the panel CS.
interface ili_fill_rect_if;
  logic       send;
  logic [7:0] data;
  logic       dc;
  logic       cs;
  logic       byte_sent;

  modport master (output send, output data, output dc, output cs, input byte_sent);
  modport slave  (input send, input data, input dc, input cs, output byte_sent);
endinterface

// File: rtl/ili_fill_rect_pix_cnt.sv
// Column/row walker for the pixel phase: x runs x0..x1, then wraps back to
// x0 while y steps down one row. o_last flags the bottom-right pixel.
// With ILI_FILL_CHECKER_EN it also exposes the checkerboard parity.
module ili_pix_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_adv,
  input  logic [15:0] i_x0,
  input  logic [15:0] i_x1,
  input  logic [15:0] i_y0,
  input  logic [15:0] i_y1,
`ifdef ILI_FILL_CHECKER_EN
  output logic        o_parity,
`endif
  output logic        o_last
);

  logic [15:0] r_x;
  logic [15:0] r_y;
  logic        w_row_end;

  assign w_row_end = (r_x == i_x1);
  assign o_last    = w_row_end && (r_y == i_y1);
`ifdef ILI_FILL_CHECKER_EN
  assign o_parity  = r_x[0] ^ r_y[0];
`endif

  // Load the top-left corner, then advance one pixel per completed colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= i_x0;
      r_y <= i_y0;
    end else if (i_adv) begin
      if (w_row_end) begin
        r_x <= i_x0;
        r_y <= r_y + 16'd1;
      end else begin
        r_x <= r_x + 16'd1;
      end
    end
  end

endmodule

// File: rtl/ili_fill_rect.sv
// ILI9341 rectangle fill: on a start strobe emits CASET/PASET/RAMWR with the
// window coordinates, then the RGB565 colour for every pixel, one byte per
// send/byte_sent handshake. Optional checkerboard pattern is enabled by
// defining ILI_FILL_CHECKER_EN (adds i_color_alt and i_checker).
module ili_fill_rect
  import pkg_ili9341::*;
#(
  parameter int LCD_W = 240,
  parameter int LCD_H = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_x0,
  input  logic [15:0] i_x1,
  input  logic [15:0] i_y0,
  input  logic [15:0] i_y1,
  input  logic [15:0] i_color,
`ifdef ILI_FILL_CHECKER_EN
  input  logic [15:0] i_color_alt,
  input  logic        i_checker,
`endif
  ili_fill_rect_if.master spi,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  e_fill_state r_state;
  e_fill_state w_next;
  st_fill_req  r_req;
  logic [3:0]  r_hdr_idx;
  logic        r_pix_phase;
  logic        r_lo;
  logic        r_err;

  logic        w_valid;
  logic        w_start_ok;
  logic        w_start_bad;
  logic        w_ack;
  logic        w_last_pix;
  logic        w_last_byte;
  logic        w_cnt_load;
  logic        w_cnt_adv;
  logic        w_active;
  logic [7:0]  w_hdr_byte;
  logic        w_hdr_dc;
  logic [15:0] w_pix_color;
  logic [7:0]  w_byte;
  logic        w_dc;

  assign w_valid = (i_x1 >= i_x0) && (i_y1 >= i_y0) &&
                   (i_x1 < 16'(LCD_W)) && (i_y1 < 16'(LCD_H));
  assign w_start_ok  = i_start && (r_state == ST_IDLE) && w_valid;
  assign w_start_bad = i_start && (r_state == ST_IDLE) && !w_valid;
  assign w_ack       = (r_state == ST_WAIT) && spi.byte_sent;
  assign w_last_byte = r_pix_phase && r_lo && w_last_pix;
  assign w_cnt_load  = w_ack && !r_pix_phase && (r_hdr_idx == HDR_LAST);
  assign w_cnt_adv   = w_ack && r_pix_phase && r_lo && !w_last_pix;

  // State register; reset drops straight back to IDLE, which releases CS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state: one SEND cycle per byte, then wait for the shifter's ack.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_next = ST_SEND;
      ST_SEND:   w_next = ST_WAIT;
      ST_WAIT:   if (w_ack) w_next = w_last_byte ? ST_FINISH : ST_SEND;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Latch the request on an accepted start and step the byte position on
  // every ack; rejected starts only raise the error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req       <= '0;
      r_hdr_idx   <= '0;
      r_pix_phase <= 1'b0;
      r_lo        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_start_bad;
      if (w_start_ok) begin
        r_req.x0    <= i_x0;
        r_req.x1    <= i_x1;
        r_req.y0    <= i_y0;
        r_req.y1    <= i_y1;
        r_req.color <= i_color;
        r_hdr_idx   <= '0;
        r_pix_phase <= 1'b0;
        r_lo        <= 1'b0;
      end else if (w_ack) begin
        if (!r_pix_phase) begin
          if (r_hdr_idx == HDR_LAST) r_pix_phase <= 1'b1;
          else                       r_hdr_idx   <= r_hdr_idx + 4'd1;
        end else begin
          r_lo <= ~r_lo;
        end
      end
    end
  end

`ifdef ILI_FILL_CHECKER_EN
  logic [15:0] r_color_alt;
  logic        r_checker;
  logic        w_parity;

  // Checkerboard settings are captured with the rest of the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_color_alt <= '0;
      r_checker   <= 1'b0;
    end else if (w_start_ok) begin
      r_color_alt <= i_color_alt;
      r_checker   <= i_checker;
    end
  end

  assign w_pix_color = (r_checker && w_parity) ? r_color_alt : r_req.color;
`else
  assign w_pix_color = r_req.color;
`endif

  ili_pix_cnt u_pix_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_cnt_load),
    .i_adv    (w_cnt_adv),
    .i_x0     (r_req.x0),
    .i_x1     (r_req.x1),
    .i_y0     (r_req.y0),
    .i_y1     (r_req.y1),
`ifdef ILI_FILL_CHECKER_EN
    .o_parity (w_parity),
`endif
    .o_last   (w_last_pix)
  );

  // Header byte for the current index; commands go out with D/C low.
  always_comb begin
    w_hdr_byte = 8'h00;
    w_hdr_dc   = 1'b1;
    case (r_hdr_idx)
      4'd0:  begin w_hdr_byte = ILI_CASET; w_hdr_dc = 1'b0; end
      4'd1:  w_hdr_byte = r_req.x0[15:8];
      4'd2:  w_hdr_byte = r_req.x0[7:0];
      4'd3:  w_hdr_byte = r_req.x1[15:8];
      4'd4:  w_hdr_byte = r_req.x1[7:0];
      4'd5:  begin w_hdr_byte = ILI_PASET; w_hdr_dc = 1'b0; end
      4'd6:  w_hdr_byte = r_req.y0[15:8];
      4'd7:  w_hdr_byte = r_req.y0[7:0];
      4'd8:  w_hdr_byte = r_req.y1[15:8];
      4'd9:  w_hdr_byte = r_req.y1[7:0];
      4'd10: begin w_hdr_byte = ILI_RAMWR; w_hdr_dc = 1'b0; end
      default: w_hdr_byte = 8'h00;
    endcase
  end

  assign w_byte   = r_pix_phase ? (r_lo ? w_pix_color[7:0] : w_pix_color[15:8]) : w_hdr_byte;
  assign w_dc     = r_pix_phase ? 1'b1 : w_hdr_dc;
  assign w_active = (r_state == ST_SEND) || (r_state == ST_WAIT);

  // Byte position only moves on an ack, so data/D/C hold through WAIT.
  assign spi.send = (r_state == ST_SEND);
  assign spi.data = w_active ? w_byte : 8'h00;
  assign spi.dc   = w_active && w_dc;
  assign spi.cs   = !w_active;
  assign o_busy   = w_active;
  assign o_done   = (r_state == ST_FINISH);
  assign o_err    = r_err;

endmodule

// File: tb/tb_ili_fill_rect.sv
// Directed bench for ili_fill_rect: drives fills, acts as the SPI shifter
// with configurable ack delay, and compares the byte stream against a
// reference built from the rectangle. Define ILI_FILL_CHECKER_EN to also
// exercise the checkerboard pattern.
module tb_ili_fill_rect;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] i_x0, i_x1, i_y0, i_y1, i_color;
`ifdef ILI_FILL_CHECKER_EN
  logic [15:0] i_color_alt;
  logic        i_checker;
`endif
  logic        o_busy, o_done, o_err;

  ili_fill_rect_if spi ();

  ili_fill_rect dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_x0        (i_x0),
    .i_x1        (i_x1),
    .i_y0        (i_y0),
    .i_y1        (i_y1),
    .i_color     (i_color),
`ifdef ILI_FILL_CHECKER_EN
    .i_color_alt (i_color_alt),
    .i_checker   (i_checker),
`endif
    .spi         (spi),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  int errCount = 0;
  int checkCount = 0;

  logic [8:0] byteQ[$];
  logic [8:0] expQ[$];
  int sendCnt, doneCnt, stableErr, gapErr, csErr, errSeen, dblSend;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference byte stream for a rectangle fill.
  function automatic void buildExpected(input logic [15:0] x0, input logic [15:0] x1,
                                        input logic [15:0] y0, input logic [15:0] y1,
                                        input logic [15:0] color, input logic [15:0] alt,
                                        input bit chk);
    logic [15:0] c;
    expQ.delete();
    expQ.push_back({1'b0, 8'h2A});
    expQ.push_back({1'b1, x0[15:8]}); expQ.push_back({1'b1, x0[7:0]});
    expQ.push_back({1'b1, x1[15:8]}); expQ.push_back({1'b1, x1[7:0]});
    expQ.push_back({1'b0, 8'h2B});
    expQ.push_back({1'b1, y0[15:8]}); expQ.push_back({1'b1, y0[7:0]});
    expQ.push_back({1'b1, y1[15:8]}); expQ.push_back({1'b1, y1[7:0]});
    expQ.push_back({1'b0, 8'h2C});
    for (int y = int'(y0); y <= int'(y1); y++) begin
      for (int x = int'(x0); x <= int'(x1); x++) begin
        c = (chk && (((x ^ y) & 1) == 1)) ? alt : color;
        expQ.push_back({1'b1, c[15:8]});
        expQ.push_back({1'b1, c[7:0]});
      end
    end
  endfunction

  function automatic int mixDelay(input int n);
    case (n % 3)
      1:       return 0;
      2:       return 1;
      default: return 50;
    endcase
  endfunction

  // Pulse start for one cycle, then scramble inputs to prove they were latched.
  task automatic applyStimulus(input logic [15:0] x0, input logic [15:0] x1,
                               input logic [15:0] y0, input logic [15:0] y1,
                               input logic [15:0] color, input logic [15:0] alt,
                               input bit chk);
    @(negedge clk);
    i_x0 = x0; i_x1 = x1; i_y0 = y0; i_y1 = y1; i_color = color;
`ifdef ILI_FILL_CHECKER_EN
    i_color_alt = alt; i_checker = chk;
`else
    if (chk && alt == 16'h0) i_color = color;
`endif
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_x0 = 16'hFFFF; i_x1 = 16'h0000; i_y0 = 16'hFFFF; i_y1 = 16'h0000; i_color = 16'h5A5A;
`ifdef ILI_FILL_CHECKER_EN
    i_color_alt = 16'hA5A5; i_checker = ~chk;
`endif
  endtask

  // Shifter model: collects bytes, acks after the chosen delay, and tallies
  // stability / gap / chip-select problems. delayMode<0 cycles 0,1,50.
  task automatic runFill(input int delayMode, input int stopAfter, input bit injectStart, input int budget);
    logic [8:0] cur;
    bit pending;
    bit injected;
    int waitCnt;
    int cycles;
    byteQ.delete();
    sendCnt = 0; doneCnt = 0; stableErr = 0; gapErr = 0; csErr = 0; errSeen = 0; dblSend = 0;
    cur = '0; pending = 0; injected = 0; waitCnt = 0; cycles = 0;
    forever begin
      if (injected) begin
        i_start = 1'b0;
        injected = 0;
      end
      if (spi.byte_sent) begin
        spi.byte_sent = 1'b0;
        pending = 0;
        if (!spi.send && !o_done) gapErr++;
      end
      if (o_err) errSeen++;
      if (o_done) doneCnt++;
      if (spi.send) begin
        if (pending) dblSend++;
        cur = {spi.dc, spi.data};
        byteQ.push_back(cur);
        sendCnt++;
        pending = 1;
        if (spi.cs || !o_busy) csErr++;
        waitCnt = (delayMode < 0) ? mixDelay(sendCnt) : delayMode;
        if (injectStart && sendCnt == 5) begin
          i_x0 = 16'd0; i_x1 = 16'd0; i_y0 = 16'd0; i_y1 = 16'd0; i_color = 16'hAAAA;
          i_start = 1'b1;
          injected = 1;
        end
      end else if (pending) begin
        if ({spi.dc, spi.data} != cur) stableErr++;
        if (spi.cs || !o_busy) csErr++;
        if (waitCnt == 0) spi.byte_sent = 1'b1;
        else waitCnt--;
      end
      if (doneCnt > 0 || (stopAfter > 0 && sendCnt >= stopAfter) || cycles >= budget) break;
      @(negedge clk);
      cycles++;
    end
    spi.byte_sent = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic compareBytes(input string tag);
    int nm = 0;
    checkOutput({tag, "_count"}, byteQ.size(), expQ.size());
    for (int i = 0; i < byteQ.size() && i < expQ.size(); i++)
      if (byteQ[i] != expQ[i]) nm++;
    checkOutput({tag, "_bytes"}, nm, 0);
  endtask

  task automatic checkHandshake(input string tag);
    checkOutput({tag, "_done"}, doneCnt, 1);
    checkOutput({tag, "_cs_busy"}, csErr, 0);
    checkOutput({tag, "_gap"}, gapErr, 0);
    checkOutput({tag, "_stable"}, stableErr, 0);
    checkOutput({tag, "_dblsend"}, dblSend, 0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, o_done, 0);
    checkOutput({tag, "_cs_after"}, spi.cs, 1);
    checkOutput({tag, "_busy_after"}, o_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [8:0] spExp [13];
    logic [8:0] ckExp [8];
    int nm;
    int sends;
    int csLow;

    spExp = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h105, 9'h02B, 9'h100, 9'h105,
              9'h100, 9'h105, 9'h02C, 9'h1F8, 9'h100};
    ckExp = '{9'h100, 9'h100, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h100, 9'h100};

    rst = 1'b1; i_start = 1'b0; spi.byte_sent = 1'b0;
    i_x0 = '0; i_x1 = '0; i_y0 = '0; i_y1 = '0; i_color = '0;
`ifdef ILI_FILL_CHECKER_EN
    i_color_alt = '0; i_checker = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_send", spi.send, 0);
    checkOutput("rst_data", spi.data, 8'h00);
    checkOutput("rst_dc", spi.dc, 0);
    checkOutput("rst_cs", spi.cs, 1);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_err", o_err, 0);
    rst = 1'b0;

    $display("[TB] single pixel");
    applyStimulus(16'd5, 16'd5, 16'd5, 16'd5, 16'hF800, 16'h0, 1'b0);
    runFill(0, 0, 1'b0, 200);
    nm = 0;
    for (int i = 0; i < 13 && i < byteQ.size(); i++) if (byteQ[i] != spExp[i]) nm++;
    checkOutput("sp_count", byteQ.size(), 13);
    checkOutput("sp_bytes", nm, 0);
    checkHandshake("sp");

    $display("[TB] handshake stall 0/1/50 with start while busy");
    applyStimulus(16'd1, 16'd2, 16'd2, 16'd2, 16'h1234, 16'h0, 1'b0);
    runFill(-1, 0, 1'b1, 3000);
    buildExpected(16'd1, 16'd2, 16'd2, 16'd2, 16'h1234, 16'h0, 1'b0);
    compareBytes("stall");
    checkOutput("stall_no_err", errSeen, 0);
    checkHandshake("stall");

    $display("[TB] rejected starts");
    applyStimulus(16'd10, 16'd9, 16'd0, 16'd0, 16'h1111, 16'h0, 1'b0);
    checkOutput("rej_x_err", o_err, 1);
    checkOutput("rej_x_cs", spi.cs, 1);
    checkOutput("rej_x_busy", o_busy, 0);
    sends = 0; csLow = 0;
    @(negedge clk);
    checkOutput("rej_x_err_pulse", o_err, 0);
    repeat (10) begin
      if (spi.send) sends++;
      if (!spi.cs) csLow++;
      @(negedge clk);
    end
    checkOutput("rej_x_nosend", sends, 0);
    checkOutput("rej_x_cs_high", csLow, 0);
    applyStimulus(16'd0, 16'd240, 16'd0, 16'd0, 16'h1111, 16'h0, 1'b0);
    checkOutput("rej_w_err", o_err, 1);
    checkOutput("rej_w_send", spi.send, 0);
    applyStimulus(16'd0, 16'd0, 16'd0, 16'd320, 16'h1111, 16'h0, 1'b0);
    checkOutput("rej_h_err", o_err, 1);
    applyStimulus(16'd0, 16'd0, 16'd7, 16'd6, 16'h1111, 16'h0, 1'b0);
    checkOutput("rej_y_err", o_err, 1);
    @(negedge clk);

    $display("[TB] bottom strip reaching both panel edges");
    applyStimulus(16'd0, 16'd239, 16'd310, 16'd319, 16'h07E0, 16'h0, 1'b0);
    runFill(0, 0, 1'b0, 20000);
    buildExpected(16'd0, 16'd239, 16'd310, 16'd319, 16'h07E0, 16'h0, 1'b0);
    compareBytes("strip");
    checkOutput("strip_sends", sendCnt, 11 + 2 * 240 * 10);
    checkOutput("strip_last", (byteQ.size() > 0) ? byteQ[byteQ.size() - 1] : 9'h000, 9'h1E0);
    checkHandshake("strip");

    $display("[TB] abort by reset mid-fill");
    applyStimulus(16'd0, 16'd3, 16'd0, 16'd3, 16'h5555, 16'h0, 1'b0);
    runFill(0, 20, 1'b0, 500);
    checkOutput("abort_sent", sendCnt, 20);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_send", spi.send, 0);
    checkOutput("abort_cs", spi.cs, 1);
    checkOutput("abort_data", spi.data, 8'h00);
    checkOutput("abort_dc", spi.dc, 0);
    checkOutput("abort_busy", o_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'd0, 16'd1, 16'd0, 16'd0, 16'hABCD, 16'h0, 1'b0);
    runFill(0, 0, 1'b0, 200);
    buildExpected(16'd0, 16'd1, 16'd0, 16'd0, 16'hABCD, 16'h0, 1'b0);
    compareBytes("post_abort");
    checkOutput("post_abort_sends", sendCnt, 15);
    checkHandshake("post_abort");

`ifdef ILI_FILL_CHECKER_EN
    $display("[TB] checkerboard");
    applyStimulus(16'd0, 16'd1, 16'd0, 16'd1, 16'h0000, 16'hFFFF, 1'b1);
    runFill(0, 0, 1'b1, 300);
    buildExpected(16'd0, 16'd1, 16'd0, 16'd1, 16'h0000, 16'hFFFF, 1'b1);
    compareBytes("chk");
    nm = 0;
    for (int i = 0; i < 8 && (i + 11) < byteQ.size(); i++) if (byteQ[i + 11] != ckExp[i]) nm++;
    checkOutput("chk_pixels", nm, 0);
    checkOutput("chk_no_err", errSeen, 0);
    checkHandshake("chk");
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
